// File: rtl/l1_mem_arbiter_if.sv
// Signal bundle between the L1 caches, the memory-port arbiter and the off-chip memory.
// The arbiter uses the slave view; caches and memory together use the master view.
interface l1_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic [DATA_W-1:0] ic_rdata;
  logic              ic_rvalid;
  logic              ic_done;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [DATA_W-1:0] dc_rdata;
  logic              dc_rvalid;
  logic              dc_done;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              busy;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
    output ic_rdata, ic_rvalid, ic_done, dc_rdata, dc_rvalid, dc_done,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
    input  ic_rdata, ic_rvalid, ic_done, dc_rdata, dc_rvalid, dc_done,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Shares the single memory port between IC refills and DC refills/write-throughs,
// sequencing BURST-word reads and single-word writes, with round-robin on ties.
module l1_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  l1_mem_arbiter_if.slave   bus
);
  localparam int BEAT_W = $clog2(BURST);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST - 1);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;
  typedef enum logic {OWN_IC, OWN_DC} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, last_grant_q, grant;
  logic [ADDR_W-1:0] base_q, req_addr;
  logic [BEAT_W-1:0] beat_q;
  logic              we_q, grant_we;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              rvalid_q;
  logic              any_req, start, beat_done, last_beat, in_xfer;

  assign any_req   = bus.ic_req || bus.dc_req;
  assign start     = (state_q == IDLE) && any_req;
  assign in_xfer   = (state_q == XFER);
  assign beat_done = in_xfer && bus.mem_ready;
  assign last_beat = we_q || (beat_q == BEAT_W'(BURST - 1));

  // A tie goes to whichever cache was not served last.
  always_comb begin
    grant = OWN_IC;
    if (bus.dc_req && (!bus.ic_req || last_grant_q == OWN_IC)) grant = OWN_DC;
  end

  assign grant_we = (grant == OWN_DC) && bus.dc_we;
  assign req_addr = (grant == OWN_DC) ? bus.dc_addr : bus.ic_addr;

  // NOTE: state_d takes its hold value first, so no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = XFER;
      XFER:    if (beat_done && last_beat) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_IC;
      last_grant_q <= OWN_IC;
      base_q       <= '0;
      beat_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      rvalid_q <= beat_done && !we_q;
      if (start) begin
        owner_q      <= grant;
        last_grant_q <= grant;
        we_q         <= grant_we;
        base_q       <= grant_we ? req_addr : (req_addr & ALIGN_MASK);
        wdata_q      <= (grant == OWN_DC) ? bus.dc_wdata : '0;
        beat_q       <= '0;
        rdata_q      <= '0;
      end
      if (beat_done) begin
        beat_q <= beat_q + BEAT_W'(1);
        if (!we_q) rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_req   = in_xfer;
  assign bus.mem_we    = in_xfer && we_q;
  assign bus.mem_addr  = in_xfer ? (base_q + ADDR_W'(beat_q)) : '0;
  assign bus.mem_wdata = in_xfer ? wdata_q : '0;

  // Only the current owner ever sees data or strobes.
  assign bus.ic_rvalid = rvalid_q && (owner_q == OWN_IC);
  assign bus.ic_done   = (state_q == RESP) && (owner_q == OWN_IC);
  assign bus.ic_rdata  = (owner_q == OWN_IC) ? rdata_q : '0;
  assign bus.dc_rvalid = rvalid_q && (owner_q == OWN_DC);
  assign bus.dc_done   = (state_q == RESP) && (owner_q == OWN_DC);
  assign bus.dc_rdata  = (owner_q == OWN_DC) ? rdata_q : '0;
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench: a transaction-level reference model is compared against every output
// on every cycle, with directed scenarios pinned by hand-computed literals plus a random soak.
module tb_l1_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int BURST  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  l1_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory contents are a fixed function of the address, so returned words reveal the address used.
  function automatic logic [31:0] mem_fn(input logic [15:0] a);
    return {~a, a};
  endfunction

  assign bus.mem_rdata = mem_fn(bus.mem_addr);

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transfer-level view) ----------------
  int          m_left  = 0;     // beats still owed by the current transfer
  int          m_beat  = 0;     // beats already accepted
  bit          m_resp  = 1'b0;  // completion cycle pending/showing
  bit          m_rv    = 1'b0;  // a read word is being returned this cycle
  bit          m_we    = 1'b0;
  bit          m_owner = 1'b0;  // 0 = IC, 1 = DC
  bit          m_last  = 1'b0;  // who was granted most recently
  logic [15:0] m_base  = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;

  initial forever begin
    bit          pick_dc;
    logic [15:0] a;
    @(posedge clk);
    if (rst) begin
      m_left = 0; m_beat = 0; m_resp = 0; m_rv = 0; m_we = 0;
      m_owner = 0; m_last = 0; m_base = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      m_rv = 1'b0;
      if (m_resp) begin
        m_resp = 1'b0;
      end else if (m_left > 0) begin
        if (bus.mem_ready) begin
          if (!m_we) begin
            m_rv    = 1'b1;
            m_rdata = mem_fn(m_base + 16'(m_beat));
          end
          m_beat++;
          m_left--;
          if (m_left == 0) m_resp = 1'b1;
        end
      end else if (bus.ic_req || bus.dc_req) begin
        pick_dc = bus.dc_req && (!bus.ic_req || !m_last);
        a       = pick_dc ? bus.dc_addr : bus.ic_addr;
        m_we    = pick_dc && bus.dc_we;
        m_base  = m_we ? a : (a & ~16'(BURST - 1));
        m_wdata = pick_dc ? bus.dc_wdata : 32'h0;
        m_left  = m_we ? 1 : BURST;
        m_beat  = 0;
        m_owner = pick_dc;
        m_last  = pick_dc;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic [127:0] act, exp;
    logic [31:0]  icr, dcr;
    logic         xfer;
    @(negedge clk);
    if (cmp_en) begin
      xfer = (m_left > 0);
      icr  = bus.ic_rdata;
      dcr  = bus.dc_rdata;
      // The owner's rdata is only defined while its strobe is high.
      if (!m_owner && !m_rv) icr = '0;
      if (m_owner && !m_rv)  dcr = '0;
      act = {bus.busy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
             bus.ic_rvalid, bus.ic_done, icr, bus.dc_rvalid, bus.dc_done, dcr};
      exp = {xfer || m_resp, xfer, xfer && m_we,
             xfer ? 16'(m_base + 16'(m_beat)) : 16'h0,
             xfer ? m_wdata : 32'h0,
             m_rv && !m_owner, m_resp && !m_owner, (m_rv && !m_owner) ? m_rdata : 32'h0,
             m_rv && m_owner,  m_resp && m_owner,  (m_rv && m_owner)  ? m_rdata : 32'h0};
      check("cycle", act, exp);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ic_req = 0; bus.ic_addr = '0;
    bus.dc_req = 0; bus.dc_we = 0; bus.dc_addr = '0; bus.dc_wdata = '0;
    bus.mem_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic ic_burst(input string tag, input logic [15:0] addr,
                          input logic [15:0] ea [4], input logic [31:0] ew [4]);
    int pulses   = 0;
    int done_at  = -1;
    bit dc_noise = 0;
    bit rv_done  = 0;
    bus.ic_req = 1; bus.ic_addr = addr; bus.mem_ready = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c < 4) check($sformatf("%s_addr%0d", tag, c), bus.mem_addr, ea[c]);
      if (bus.ic_rvalid) begin
        if (pulses < 4) check($sformatf("%s_word%0d", tag, pulses), bus.ic_rdata, ew[pulses]);
        pulses++;
      end
      if (bus.ic_done) begin
        done_at = c; rv_done = bus.ic_rvalid; bus.ic_req = 0;
      end
      if (bus.dc_rvalid || bus.dc_done || bus.dc_rdata != 0) dc_noise = 1;
    end
    check({tag, "_pulses"}, pulses, 4);
    check({tag, "_done_cycle"}, done_at, 4);
    check({tag, "_rvalid_with_done"}, rv_done, 1);
    check({tag, "_dc_quiet"}, dc_noise, 0);
  endtask

  task automatic both_tie(output bit dc_first);
    bit ic_open = 1, dc_open = 1;
    int first = 0;
    bus.ic_req = 1; bus.ic_addr = 16'h0080;
    bus.dc_req = 1; bus.dc_we = 0; bus.dc_addr = 16'h0040;
    bus.mem_ready = 1;
    for (int c = 0; c < 40 && (ic_open || dc_open); c++) begin
      tick();
      if (bus.dc_done) begin bus.dc_req = 0; dc_open = 0; if (first == 0) first = 2; end
      if (bus.ic_done) begin bus.ic_req = 0; ic_open = 0; if (first == 0) first = 1; end
    end
    check("tie_both_served", ic_open || dc_open, 0);
    dc_first = (first == 2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] ea [4];
    logic [31:0] ew [4];
    bit          dcf;
    int          addr_err, req_drop, pulses, done_at, n_done;
    bit          got;

    idle_inputs();
    tick();
    cmp_en = 1'b1;

    // Reset state.
    do_reset();
    check("rst_busy", bus.busy, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_ic_done", bus.ic_done, 0);
    check("rst_dc_rvalid", bus.dc_rvalid, 0);

    // IC burst read from an unaligned address.
    ea = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    ew = '{32'hFFEF0010, 32'hFFEE0011, 32'hFFED0012, 32'hFFEC0013};
    ic_burst("icrd", 16'h0013, ea, ew);

    // Tie straight after reset: DC first, then IC; a repeated tie again favours DC.
    do_reset();
    both_tie(dcf);
    check("tie1_dc_first", dcf, 1);
    tick();
    both_tie(dcf);
    check("tie2_dc_first", dcf, 1);

    // DC single-word write.
    do_reset();
    bus.dc_we = 1; bus.dc_addr = 16'h1234; bus.dc_wdata = 32'hDEADBEEF;
    bus.dc_req = 1; bus.mem_ready = 1;
    tick();
    check("wr_mem_we", bus.mem_we, 1);
    check("wr_mem_addr", bus.mem_addr, 16'h1234);
    check("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("wr_no_early_done", bus.dc_done, 0);
    tick();
    check("wr_done", bus.dc_done, 1);
    check("wr_no_rvalid", bus.dc_rvalid, 0);
    check("wr_single_xfer", bus.mem_req, 0);
    bus.dc_req = 0; bus.dc_we = 0;

    // DC read with the memory ready only every third cycle.
    do_reset();
    bus.dc_req = 1; bus.dc_we = 0; bus.dc_addr = 16'h0200;
    addr_err = 0; req_drop = 0; pulses = 0; done_at = -1;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c < 12) begin
        if (bus.mem_addr !== 16'h0200 + 16'(c / 3)) addr_err++;
        if (bus.mem_req !== 1'b1) req_drop++;
      end
      if (bus.dc_rvalid) pulses++;
      if (bus.dc_done) begin done_at = c; bus.dc_req = 0; end
      bus.mem_ready = (c % 3 == 2);
    end
    check("ws_addr_hold", addr_err, 0);
    check("ws_req_steady", req_drop, 0);
    check("ws_pulses", pulses, 4);
    check("ws_done_cycle", done_at, 12);

    // Reset in the middle of an IC burst, then the held request restarts at beat 0.
    do_reset();
    bus.ic_req = 1; bus.ic_addr = 16'h0020; bus.mem_ready = 1;
    tick();
    check("mid_beat0", bus.mem_addr, 16'h0020);
    tick();
    check("mid_beat1", bus.mem_addr, 16'h0021);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_mem_req", bus.mem_req, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_no_done", bus.ic_done, 0);
    check("mid_rst_no_rvalid", bus.ic_rvalid, 0);
    rst = 1'b0;
    tick();
    check("mid_restart_addr", bus.mem_addr, 16'h0020);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (bus.ic_done) begin got = 1; bus.ic_req = 0; end
    end
    check("mid_restart_done", got, 1);

    // Burst at the top of the address space wraps within ADDR_W bits.
    do_reset();
    ea = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF};
    ew = '{32'h0003FFFC, 32'h0002FFFD, 32'h0001FFFE, 32'h0000FFFF};
    ic_burst("wrap", 16'hFFFE, ea, ew);

    // Random soak: both caches obey the hold-until-done rule, memory stalls randomly.
    do_reset();
    n_done = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (bus.ic_done || bus.dc_done) n_done++;
      if (bus.ic_req) begin
        if (bus.ic_done) bus.ic_req = 0;
        else if ($urandom_range(0, 5) == 0) bus.ic_addr = 16'($urandom);
      end else if (c < 3900 && $urandom_range(0, 2) == 0) begin
        bus.ic_req = 1; bus.ic_addr = 16'($urandom);
      end
      if (bus.dc_req) begin
        if (bus.dc_done) bus.dc_req = 0;
        else if ($urandom_range(0, 5) == 0) begin
          bus.dc_addr = 16'($urandom); bus.dc_we = ($urandom_range(0, 2) == 0);
          bus.dc_wdata = $urandom;
        end
      end else if (c < 3900 && $urandom_range(0, 2) == 0) begin
        bus.dc_req = 1; bus.dc_addr = 16'($urandom);
        bus.dc_we = ($urandom_range(0, 2) == 0); bus.dc_wdata = $urandom;
      end
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      rst = (c < 3900) && ($urandom_range(0, 599) == 0);
    end
    check("rand_drained", {bus.busy, bus.ic_req, bus.dc_req}, 3'b000);
    check("rand_activity", n_done > 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Shared main-memory port controller sitting between the L1 instruction cache, the L1 data cache and the single off-chip memory port. It arbitrates between IC refill and DC refill/write-through requests, sequences multi-word burst reads with a beat counter, and returns data and completion strobes to the owning cache. The caches hold their `IC_stall`/`DC_stall` toward the core until the arbiter signals done.

## Interface
- `ADDR_W`, 16, word address width; matches the core's `mem_size`.
- `DATA_W`, 32, data word width.
- `BURST`, 4, words per read burst; a power of 2, at least 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ic_req`  in  1  IC read request; held high until `ic_done` is seen.
- `ic_addr`  in  ADDR_W  IC word address; the low log2(BURST) bits are ignored.
- `ic_rdata`  out  DATA_W  returned read word.
- `ic_rvalid`  out  1  one-cycle strobe per returned word.
- `ic_done`  out  1  one-cycle completion strobe.
- `dc_req`  in  1  DC request; held high until `dc_done` is seen.
- `dc_we`  in  1  1 = single-word write, 0 = burst read.
- `dc_addr`  in  ADDR_W  DC word address; block-aligned for reads, exact for writes.
- `dc_wdata`  in  DATA_W  write data.
- `dc_rdata`  out  DATA_W  returned read word.
- `dc_rvalid`  out  1  one-cycle strobe per returned word.
- `dc_done`  out  1  one-cycle completion strobe.
- `mem_req`  out  1  memory request, held for the whole transfer.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory word address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid when `mem_ready` is high.
- `mem_ready`  in  1  beat accepted/completed this cycle.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, XFER, RESP.
- **IDLE:**
  - If `ic_req` or `dc_req` is high, grant a requester and go to XFER.
  - On the same edge, latch `owner`, base address, `we` and `wdata`, and clear the beat counter.
  - For reads, the latched base has its low log2(BURST) bits forced to 0.
  - IC requests are always reads.
- **Arbitration:**
  - If only one requester is high, grant it.
  - If both are high, grant the one that is not `last_grant`.
  - `last_grant` updates on every grant.
  - `last_grant` resets to IC, so the first tie after reset goes to DC.
- **XFER:**
  - `mem_req`=1, `mem_we`=latched `we`, `mem_wdata`=latched `wdata`.
  - `mem_addr`=(base + beat) mod 2^ADDR_W.
  - On each `mem_ready`:
    - Reads: register `mem_rdata` to the owner's `rdata`, with `rvalid` high in the next cycle.
    - Increment the beat counter.
  - Last beat (beat = BURST−1 for reads, beat 0 for writes) accepted with `mem_ready` → go to RESP.
- **RESP:**
  - One cycle; the owner's `done`=1.
  - For reads, the final word's `rvalid` coincides with `done`.
  - Next state is IDLE unconditionally.
  - Requests are not sampled in RESP.
- **Requester rule:** the requester deasserts `req` at the edge after it samples `done`, so the request is low in the following IDLE cycle.
- Non-owner outputs stay 0 throughout.
- `mem_ready` is ignored outside XFER.
- Request or address changes during XFER are ignored, because the transfer uses the latched values.

## Timing
- **Reset values:** every output is 0, state = IDLE, beat = 0, `last_grant` = IC.
- **Reset mid-transfer:**
  - Next cycle shows IDLE with `mem_req`=0.
  - No `done` and no further `rvalid` are produced.
  - The requester re-issues its request.
- **Latency:** request seen in IDLE at edge k → XFER from cycle k.
- **Zero-wait memory:** a read's `done` arrives BURST+1 cycles after the grant edge; a write's `done` arrives 2 cycles after it.
- **Wait states:** `mem_addr` is held stable until `mem_ready`.
- **Back-to-back:** the minimum gap between one `done` and the next grant edge is 1 cycle (the IDLE cycle).
- **`busy`:** high in XFER and RESP.

## Test plan
- **IC burst read:** reset, then `ic_req`=1 with `ic_addr`=0x0013 and `mem_ready` tied high.
  - `mem_addr` = 0x0010, 0x0011, 0x0012, 0x0013 on consecutive cycles.
  - Four `ic_rvalid` pulses carry the memory words in order.
  - `ic_done` is high with the 4th pulse.
  - `dc_*` outputs stay 0.
- **Tie arbitration:** `ic_req`=`dc_req`=1 in the same cycle right after reset.
  - DC is served first, then IC.
  - Repeating the tie afterwards grants DC again, because `last_grant`=IC.
  - Grants alternate while both are held.
- **DC write:** `dc_we`=1, `dc_addr`=0x1234, `dc_wdata`=0xDEADBEEF.
  - One XFER cycle with `mem_we`=1 carrying that address and data.
  - `dc_done` pulses 2 cycles after the grant.
  - No `dc_rvalid`.
- **Wait states:** a DC read with `mem_ready` high only every 3rd cycle.
  - `mem_addr` holds each beat address for 3 cycles.
  - `mem_req` stays high continuously.
  - Exactly 4 `dc_rvalid` pulses.
- **Reset mid-burst:** assert `rst` after beat 1 of an IC read.
  - The next cycle shows `mem_req`=0, `busy`=0, no `ic_done`.
  - A fresh `ic_req` restarts the burst at beat 0.
- **Address wrap:** IC read with `ic_addr`=0xFFFE.
  - Aligned base is 0xFFFC.
  - Addresses are 0xFFFC to 0xFFFF, with no overflow into a 17th bit.
